// File: rtl/wb_sram_ctl_pkg.sv
// wb_sram_ctl_pkg: bus and SRAM widths shared by the controller, its interface and the bench
package wb_sram_ctl_pkg;
  localparam int RAM_ADDR_WIDTH = 17;
  localparam int WB_ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH     = 16;
endpackage

// File: rtl/wb_sram_ctl_if.sv
// wb_sram_ctl_if: Wishbone slave side plus async SRAM pins of the controller
interface wb_sram_ctl_if;
  import wb_sram_ctl_pkg::*;
  logic [WB_ADDR_WIDTH-1:0]  wb_addr_i;
  logic [DATA_WIDTH-1:0]     wb_data_i;
  logic [DATA_WIDTH-1:0]     wb_data_o;
  logic                      wb_we_i;
  logic                      wb_cycle_i;
  logic                      wb_strobe_i;
  logic                      wb_stall_o;
  logic                      wb_ack_o;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_o;
  logic [DATA_WIDTH-1:0]     ram_data_i;
  logic [DATA_WIDTH-1:0]     ram_data_o;
  logic                      ram_data_oe_o;
  logic                      ram_oe_n_o;
  logic                      ram_we_n_o;
  logic                      ram_ce_n_o;
  modport slave (
    input  wb_addr_i, wb_data_i, wb_we_i, wb_cycle_i, wb_strobe_i, ram_data_i,
    output wb_data_o, wb_stall_o, wb_ack_o, ram_addr_o, ram_data_o, ram_data_oe_o,
           ram_oe_n_o, ram_we_n_o, ram_ce_n_o
  );
  modport master (
    output wb_addr_i, wb_data_i, wb_we_i, wb_cycle_i, wb_strobe_i, ram_data_i,
    input  wb_data_o, wb_stall_o, wb_ack_o, ram_addr_o, ram_data_o, ram_data_oe_o,
           ram_oe_n_o, ram_we_n_o, ram_ce_n_o
  );
endinterface

// File: rtl/wb_sram_ctl.sv
// wb_sram_ctl: Wishbone pipelined slave driving an async SRAM, one transfer per WAIT_STATES+4 cycles
module wb_sram_ctl import wb_sram_ctl_pkg::*; #(
  parameter int WAIT_STATES = 1
) (
  input logic          wb_clock_i,
  input logic          wb_reset_n_i,
  wb_sram_ctl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t                    r_state;
  logic [2:0]                r_cnt;
  logic [RAM_ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]     r_wdat;
  logic [DATA_WIDTH-1:0]     r_rdat;
  logic                      r_we;
  logic                      r_cyc;
  logic                      r_ack;
  logic                      r_ce_n;
  logic                      r_oe_n;
  logic                      r_we_n;
  logic                      r_doe;
  logic                      w_req;
  assign w_req = bus.wb_cycle_i && bus.wb_strobe_i;
  // r_cyc remembers whether the master kept CYC up for the whole transfer
  always_ff @(posedge wb_clock_i)
    if (!wb_reset_n_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdat  <= '0;
      r_rdat  <= '0;
      r_we    <= 1'b0;
      r_cyc   <= 1'b0;
      r_ack   <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_doe   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_req) begin
          r_state <= SETUP;
          r_addr  <= bus.wb_addr_i[RAM_ADDR_WIDTH-1:0];
          r_we    <= bus.wb_we_i;
          r_wdat  <= bus.wb_data_i;
          r_cyc   <= 1'b1;
          r_ce_n  <= 1'b0;
          r_oe_n  <= bus.wb_we_i;
          r_doe   <= bus.wb_we_i;
        end
        SETUP: begin
          r_state <= ACCESS;
          r_cnt   <= '0;
          r_we_n  <= !r_we;
          r_cyc   <= r_cyc && bus.wb_cycle_i;
        end
        ACCESS: begin
          r_cyc <= r_cyc && bus.wb_cycle_i;
          if (r_cnt == 3'(WAIT_STATES)) begin
            r_state <= DONE;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_ack   <= r_cyc && bus.wb_cycle_i;
            if (!r_we) r_rdat <= bus.ram_data_i;
          end else r_cnt <= r_cnt + 3'd1;
        end
        DONE: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_ack   <= 1'b0;
          r_ce_n  <= 1'b1;
          r_doe   <= 1'b0;
        end
      endcase
    end
  assign bus.wb_stall_o    = r_state != IDLE;
  assign bus.wb_ack_o      = r_ack;
  assign bus.wb_data_o     = r_rdat;
  assign bus.ram_addr_o    = r_addr;
  assign bus.ram_data_o    = r_wdat;
  assign bus.ram_data_oe_o = r_doe;
  assign bus.ram_ce_n_o    = r_ce_n;
  assign bus.ram_oe_n_o    = r_oe_n;
  assign bus.ram_we_n_o    = r_we_n;
endmodule

// File: tb/tb_wb_sram_ctl.sv
// tb_wb_sram_ctl: directed checks of two controllers (WAIT_STATES 0 and 1) against behavioural SRAMs
module tb_wb_sram_ctl;
  import wb_sram_ctl_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  wb_sram_ctl_if b0 ();
  wb_sram_ctl_if b1 ();
  wb_sram_ctl #(.WAIT_STATES(0)) u0 (.wb_clock_i(clk), .wb_reset_n_i(rst_n), .bus(b0.slave));
  wb_sram_ctl #(.WAIT_STATES(1)) u1 (.wb_clock_i(clk), .wb_reset_n_i(rst_n), .bus(b1.slave));
  logic                  sel = 1'b0;
  logic                  cyc = 1'b0;
  logic                  stb = 1'b0;
  logic                  we = 1'b0;
  logic [31:0]           addr = '0;
  logic [15:0]           wdat = '0;
  logic [31:0]           addr2 = '0;
  logic [15:0]           wdat2 = '0;
  logic [DATA_WIDTH-1:0] mem0 [0:(1<<RAM_ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] mem1 [0:(1<<RAM_ADDR_WIDTH)-1];
  assign b0.wb_cycle_i  = cyc && sel;
  assign b1.wb_cycle_i  = cyc && !sel;
  assign b0.wb_strobe_i = stb;
  assign b1.wb_strobe_i = stb;
  assign b0.wb_we_i     = we;
  assign b1.wb_we_i     = we;
  assign b0.wb_addr_i   = addr;
  assign b1.wb_addr_i   = addr;
  assign b0.wb_data_i   = wdat;
  assign b1.wb_data_i   = wdat;
  assign b0.ram_data_i  = (!b0.ram_ce_n_o && !b0.ram_oe_n_o) ? mem0[b0.ram_addr_o] : '0;
  assign b1.ram_data_i  = (!b1.ram_ce_n_o && !b1.ram_oe_n_o) ? mem1[b1.ram_addr_o] : '0;
  always @(posedge clk) begin
    if (!b0.ram_ce_n_o && !b0.ram_we_n_o) mem0[b0.ram_addr_o] <= b0.ram_data_o;
    if (!b1.ram_ce_n_o && !b1.ram_we_n_o) mem1[b1.ram_addr_o] <= b1.ram_data_o;
  end
  logic        m_stall, m_ack, m_ce_n, m_oe_n, m_we_n, m_doe;
  logic [15:0] m_rdata, m_rdo;
  logic [16:0] m_raddr;
  assign m_stall = sel ? b0.wb_stall_o    : b1.wb_stall_o;
  assign m_ack   = sel ? b0.wb_ack_o      : b1.wb_ack_o;
  assign m_ce_n  = sel ? b0.ram_ce_n_o    : b1.ram_ce_n_o;
  assign m_oe_n  = sel ? b0.ram_oe_n_o    : b1.ram_oe_n_o;
  assign m_we_n  = sel ? b0.ram_we_n_o    : b1.ram_we_n_o;
  assign m_doe   = sel ? b0.ram_data_oe_o : b1.ram_data_oe_o;
  assign m_rdata = sel ? b0.wb_data_o     : b1.wb_data_o;
  assign m_rdo   = sel ? b0.ram_data_o    : b1.ram_data_o;
  assign m_raddr = sel ? b0.ram_addr_o    : b1.ram_addr_o;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          viol = 0;
  logic [15:0] v_stall, v_ack, v_we, v_oe, v_ce, v_doe;
  logic [15:0] d_snap, r_snap;
  logic [16:0] a_snap;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic s, input logic w, input logic [31:0] a, input logic [15:0] d);
    sel = s; we = w; addr = a; wdat = d; cyc = 1'b1; stb = 1'b1;
  endtask
  // cycle n is the clock period following the n-th edge after acceptance
  task automatic run(input int ncyc, input int stb_off, input int cyc_off, input int rst_at, input bit swap);
    v_stall = '0; v_ack = '0; v_we = '0; v_oe = '0; v_ce = '0; v_doe = '0;
    d_snap = '0; r_snap = '0; a_snap = '0;
    tick();
    for (int n = 1; n <= ncyc; n++) begin
      if (n == stb_off) stb = 1'b0;
      if (n == cyc_off) cyc = 1'b0;
      if (n == rst_at) rst_n = 1'b0;
      if (n == rst_at + 1) rst_n = 1'b1;
      if (swap && n == 1) begin addr = addr2; wdat = wdat2; end
      v_stall[n] = m_stall; v_ack[n] = m_ack; v_we[n] = !m_we_n;
      v_oe[n] = !m_oe_n; v_ce[n] = !m_ce_n; v_doe[n] = m_doe;
      if ((!m_we_n && !m_oe_n) || (!m_we_n && !m_doe)) viol++;
      if (n == 1) a_snap = m_raddr;
      if (!m_we_n) d_snap = m_rdo;
      if (m_ack) r_snap = m_rdata;
      tick();
    end
    cyc = 1'b0; stb = 1'b0;
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_stall", m_stall, 0);
    chk("rst_ack", m_ack, 0);
    chk("rst_strobes", {m_ce_n, m_oe_n, m_we_n}, 3'b111);
    chk("rst_doe", m_doe, 0);
    chk("rst_rdata", m_rdata, 0);
    rst_n = 1'b1;
    tick();
    start(1'b0, 1'b1, 32'h0123, 16'h00A5);
    run(6, 1, 99, 99, 1'b0);
    chk("wr_stall", v_stall, 16'h001E);
    chk("wr_ack", v_ack, 16'h0010);
    chk("wr_we_lo", v_we, 16'h000C);
    chk("wr_oe_lo", v_oe, 16'h0000);
    chk("wr_doe", v_doe, 16'h001E);
    chk("wr_ce_lo", v_ce, 16'h001E);
    chk("wr_ram_addr", a_snap, 17'h00123);
    chk("wr_ram_data", d_snap, 16'h00A5);
    chk("wr_mem", mem1[17'h00123], 16'h00A5);
    start(1'b0, 1'b0, 32'h0123, 16'h0000);
    run(6, 1, 99, 99, 1'b0);
    chk("rd_oe_lo", v_oe, 16'h000E);
    chk("rd_we_lo", v_we, 16'h0000);
    chk("rd_ack", v_ack, 16'h0010);
    chk("rd_data_ack", r_snap, 16'h00A5);
    chk("rd_data_hold", m_rdata, 16'h00A5);
    addr2 = 32'h0201; wdat2 = 16'h2222;
    start(1'b0, 1'b1, 32'h0200, 16'h1111);
    run(11, 6, 99, 99, 1'b1);
    chk("b2b_stall", v_stall, 16'h03DE);
    chk("b2b_ack", v_ack, 16'h0210);
    chk("b2b_mem_a", mem1[17'h00200], 16'h1111);
    chk("b2b_mem_b", mem1[17'h00201], 16'h2222);
    start(1'b1, 1'b1, 32'h0002_0123, 16'h5A5A);
    run(5, 1, 99, 99, 1'b0);
    chk("ws0_stall", v_stall, 16'h000E);
    chk("ws0_ack", v_ack, 16'h0008);
    chk("ws0_we_lo", v_we, 16'h0004);
    chk("ws0_alias_addr", a_snap, 17'h00123);
    chk("ws0_mem", mem0[17'h00123], 16'h5A5A);
    chk("ws1_mem_untouched", mem1[17'h00123], 16'h00A5);
    start(1'b1, 1'b0, 32'h0000_0123, 16'h0000);
    run(5, 1, 99, 99, 1'b0);
    chk("ws0_rd_ack", v_ack, 16'h0008);
    chk("ws0_rd_oe_lo", v_oe, 16'h0006);
    chk("ws0_rd_data", r_snap, 16'h5A5A);
    start(1'b0, 1'b1, 32'h0456, 16'h1234);
    run(6, 1, 2, 99, 1'b0);
    chk("drop_ack", v_ack, 16'h0000);
    chk("drop_we_lo", v_we, 16'h000C);
    chk("drop_stall", v_stall, 16'h001E);
    chk("drop_mem", mem1[17'h00456], 16'h1234);
    start(1'b0, 1'b1, 32'h0789, 16'hBEEF);
    run(5, 1, 99, 2, 1'b0);
    chk("rst_mid_ack", v_ack, 16'h0000);
    chk("rst_mid_stall", v_stall, 16'h0006);
    chk("rst_mid_ce_lo", v_ce, 16'h0006);
    chk("rst_mid_doe", v_doe, 16'h0006);
    chk("rst_mid_we_lo", v_we, 16'h0004);
    chk("rst_mid_rdata", m_rdata, 16'h0000);
    start(1'b0, 1'b0, 32'h0123, 16'h0000);
    run(6, 1, 99, 99, 1'b0);
    chk("post_rst_ack", v_ack, 16'h0010);
    chk("post_rst_data", r_snap, 16'h00A5);
    chk("we_oe_overlap", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
